// File: rtl/bpsk_tx_sequencer_if.sv
// Payload source handshake between an upstream bit source and bpsk_tx_sequencer.
// The source (master) keeps data_in/data_valid presented; the sequencer (slave) pulses data_rd for
// one cycle when it consumes the presented bit, and the source advances on each data_rd pulse.
// A consume with data_valid=0 is an underflow: the sequencer sends 0 and the source still advances.
interface bpsk_tx_sequencer_if;
  logic data_in;
  logic data_valid;
  logic data_rd;

  modport master (
    output data_in,
    output data_valid,
    input  data_rd
  );

  modport slave (
    input  data_in,
    input  data_valid,
    output data_rd
  );
endinterface

// File: rtl/bpsk_tx_sequencer.sv
// Framed BPSK symbol sequencer: paces symbol strobes at a programmable interval and
// emits preamble, payload (pulled from the source handshake) and guard symbols.
module bpsk_tx_sequencer #(
  parameter int PREAMBLE_LEN = 32,
  parameter int GUARD_LEN    = 8,
  parameter int CNT_W        = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic [CNT_W-1:0]     interval_i,
  input  logic [CNT_W-1:0]     payload_len_i,
  bpsk_tx_sequencer_if.slave   src,
  output logic                 sym_en_o,
  output logic                 bit_out_o,
  output logic [1:0]           phase_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 underflow_o,
  output logic [1:0]           state_dbg_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRE   = 2'd1,
    S_PAY   = 2'd2,
    S_GUARD = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PREAMBLE_LEN - 1);
  localparam logic [CNT_W-1:0] GRD_LAST = CNT_W'(GUARD_LEN - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] sym_cnt_q, sym_cnt_d;
  logic [CNT_W-1:0] int_q, int_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             sym_en_q, sym_en_d;
  logic             data_rd_q, data_rd_d;
  logic             bit_q, bit_d;
  logic [1:0]       phase_q, phase_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             under_q, under_d;
  logic             tick;

  // int_q is at least 1 whenever the FSM is out of IDLE, so int_q-1 never wraps here.
  assign tick = (state_q != S_IDLE) && (cnt_q == (int_q - ONE));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      sym_cnt_q <= '0;
      int_q     <= '0;
      len_q     <= '0;
      sym_en_q  <= 1'b0;
      data_rd_q <= 1'b0;
      bit_q     <= 1'b0;
      phase_q   <= 2'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      under_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sym_cnt_q <= sym_cnt_d;
      int_q     <= int_d;
      len_q     <= len_d;
      sym_en_q  <= sym_en_d;
      data_rd_q <= data_rd_d;
      bit_q     <= bit_d;
      phase_q   <= phase_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      under_q   <= under_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sym_cnt_d = sym_cnt_q;
    int_d     = int_q;
    len_d     = len_q;
    sym_en_d  = 1'b0;
    data_rd_d = 1'b0;
    bit_d     = bit_q;
    phase_d   = phase_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    under_d   = under_q;

    if (state_q == S_IDLE) begin
      busy_d  = 1'b0;
      phase_d = S_IDLE;
      // done_q marks the first IDLE cycle after a frame; a start seen there is dropped.
      if (start_i && !done_q) begin
        int_d     = (interval_i == '0) ? ONE : interval_i;
        len_d     = payload_len_i;
        cnt_d     = '0;
        sym_cnt_d = '0;
        under_d   = 1'b0;
        state_d   = S_PRE;
        busy_d    = 1'b1;
        phase_d   = S_PRE;
      end
    end else if (abort_i) begin
      state_d   = S_IDLE;
      cnt_d     = '0;
      sym_cnt_d = '0;
      busy_d    = 1'b0;
      phase_d   = S_IDLE;
    end else begin
      phase_d = state_q;
      cnt_d   = tick ? '0 : cnt_q + ONE;
      if (tick) begin
        sym_en_d  = 1'b1;
        sym_cnt_d = sym_cnt_q + ONE;
        case (state_q)
          S_PRE: begin
            bit_d = ~sym_cnt_q[0];
            if (sym_cnt_q == PRE_LAST) begin
              sym_cnt_d = '0;
              state_d   = (len_q == '0) ? S_GUARD : S_PAY;
            end
          end
          S_PAY: begin
            data_rd_d = 1'b1;
            bit_d     = src.data_valid & src.data_in;
            if (!src.data_valid) under_d = 1'b1;
            if (sym_cnt_q == (len_q - ONE)) begin
              sym_cnt_d = '0;
              state_d   = S_GUARD;
            end
          end
          default: begin
            bit_d = 1'b0;
            if (sym_cnt_q == GRD_LAST) begin
              sym_cnt_d = '0;
              state_d   = S_IDLE;
              done_d    = 1'b1;
            end
          end
        endcase
      end
    end
  end

  assign src.data_rd = data_rd_q;
  assign sym_en_o    = sym_en_q;
  assign bit_out_o   = bit_q;
  assign phase_o     = phase_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign underflow_o = under_q;
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_bpsk_tx_sequencer.sv
// Bench for bpsk_tx_sequencer: frame-level model compared every cycle, plus literal frame checks.
module tb_bpsk_tx_sequencer;
  localparam int P = 32;
  localparam int G = 8;
  localparam int W = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [W-1:0] interval = '0;
  logic [W-1:0] payload_len = '0;
  logic         sym_en, bit_out, busy, done, underflow;
  logic [1:0]   phase, state_dbg;

  bpsk_tx_sequencer_if bus ();

  bpsk_tx_sequencer #(.PREAMBLE_LEN(P), .GUARD_LEN(G), .CNT_W(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start),
    .abort_i       (abort),
    .interval_i    (interval),
    .payload_len_i (payload_len),
    .src           (bus.slave),
    .sym_en_o      (sym_en),
    .bit_out_o     (bit_out),
    .phase_o       (phase),
    .busy_o        (busy),
    .done_o        (done),
    .underflow_o   (underflow),
    .state_dbg_o   (state_dbg)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40) $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- payload source ----------------
  logic [1:0] src_q[$];  // {valid, bit}, head is presented
  always @(negedge clk) begin
    if (bus.data_rd && src_q.size() > 0) src_q.delete(0);
    if (src_q.size() > 0) begin
      bus.data_valid = src_q[0][1];
      bus.data_in    = src_q[0][0];
    end else begin
      bus.data_valid = 1'b0;
      bus.data_in    = 1'b0;
    end
  end

  // ---------------- frame model ----------------
  // Symbol n of a frame appears after edge start+(n+1)*iv; its content follows from n alone.
  bit         m_act = 0;
  int         m_k = 0, m_iv = 0, m_len = 0;
  logic       e_sym = 0, e_rd = 0, e_bit = 0, e_busy = 0, e_done = 0, e_under = 0;
  logic [1:0] e_phase = 0;

  function automatic logic [1:0] phase_of(input int n, input int len);
    if (n < P) return 2'd1;
    if (n < P + len) return 2'd2;
    return 2'd3;
  endfunction

  always @(posedge clk) begin
    int  n;
    logic prev_done;
    if (!rst) begin
      m_act = 0; m_k = 0; m_iv = 0; m_len = 0;
      e_sym = 0; e_rd = 0; e_bit = 0; e_busy = 0; e_done = 0; e_under = 0; e_phase = 0;
    end else begin
      prev_done = e_done;
      e_sym = 0; e_rd = 0; e_done = 0;
      if (!m_act) begin
        if (start && !prev_done) begin
          m_act = 1; m_k = 0;
          m_iv = (interval == 0) ? 1 : int'(interval);
          m_len = int'(payload_len);
          e_under = 0; e_busy = 1; e_phase = 2'd1;
        end else begin
          e_busy = 0; e_phase = 2'd0;
        end
      end else if (abort) begin
        m_act = 0; e_busy = 0; e_phase = 2'd0;
      end else begin
        m_k++;
        if (m_k % m_iv == 0) begin
          n = m_k / m_iv - 1;
          e_sym = 1;
          e_phase = phase_of(n, m_len);
          if (e_phase == 2'd1) e_bit = (n % 2 == 0);
          else if (e_phase == 2'd2) begin
            e_rd = 1;
            e_bit = bus.data_valid ? bus.data_in : 1'b0;
            if (!bus.data_valid) e_under = 1;
          end else e_bit = 0;
          if (n == P + m_len + G - 1) begin
            e_done = 1;
            m_act = 0;
          end
        end else begin
          e_phase = phase_of(m_k / m_iv, m_len);
        end
      end
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    chk("sym_en", sym_en, e_sym);
    chk("data_rd", bus.data_rd, e_rd);
    chk("bit_out", bit_out, e_bit);
    chk("phase", phase, e_phase);
    chk("busy", busy, e_busy);
    chk("done", done, e_done);
    chk("underflow", underflow, e_under);
  end

  // ---------------- driver ----------------
  logic       rec_bits[$];
  logic [1:0] rec_ph[$];
  int         rec_j[$];
  int         done_j, rd_cnt;
  logic       under_at_done, under_first;

  task automatic check_all_zero(input string tag);
    chk({tag, "_sym_en"}, sym_en, 0);
    chk({tag, "_data_rd"}, bus.data_rd, 0);
    chk({tag, "_bit_out"}, bit_out, 0);
    chk({tag, "_phase"}, phase, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_underflow"}, underflow, 0);
  endtask

  // j = index of the cycle following edge start+j (start sampled at edge j=0).
  task automatic run_frame(input int iv, input int len, input int abort_edge,
                           input int mid_start_edge, input bit start_on_done, input int rst_j);
    int  j, extra;
    bit  finished;
    rec_bits.delete(); rec_ph.delete(); rec_j.delete();
    done_j = -1; rd_cnt = 0; under_at_done = 0; under_first = 1'bx;
    @(negedge clk);
    interval = W'(iv); payload_len = W'(len); start = 1'b1;
    j = -1; extra = 0; finished = 0;
    while (!finished) begin
      @(negedge clk);
      j++;
      if (j == 0) begin
        under_first = underflow;
        interval = W'(iv + 3);
        payload_len = W'(len + 5);
      end
      if (sym_en) begin
        rec_bits.push_back(bit_out);
        rec_ph.push_back(phase);
        rec_j.push_back(j);
      end
      if (bus.data_rd) rd_cnt++;
      if (done) begin
        done_j = j;
        under_at_done = underflow;
      end
      if (abort_edge > 0 && j == abort_edge) begin
        chk("abort_sym_suppressed", sym_en, 0);
        chk("abort_busy", busy, 0);
        chk("abort_phase", phase, 0);
      end
      start = (j + 1 == mid_start_edge) || (start_on_done && done);
      abort = (j + 1 == abort_edge);
      if (j == rst_j) begin
        #2 rst = 1'b0;
        #1 check_all_zero("async_rst");
        finished = 1;
      end else if (done_j >= 0 || (abort_edge > 0 && j >= abort_edge)) begin
        extra++;
        if (extra > 6) finished = 1;
      end
      if (j > 6000) begin
        chk("frame_timeout", 1, 0);
        finished = 1;
      end
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    int bad;
    logic exp_b;
    bus.data_in = 1'b0;
    bus.data_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;
    repeat (2) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_abort_busy", busy, 0);

    // Frame 1: interval 4, payload 1,1,0.
    src_q = '{2'b11, 2'b11, 2'b10};
    run_frame(4, 3, 0, 0, 0, -1);
    chk("t1_pulses", rec_bits.size(), 43);
    chk("t1_first_j", rec_j.size() > 0 ? rec_j[0] : -1, 4);
    chk("t1_done_j", done_j, 172);
    chk("t1_rd_cnt", rd_cnt, 3);
    bad = 0;
    for (int i = 0; i < rec_bits.size(); i++) begin
      exp_b = (i < P) ? (i % 2 == 0) : (i == 32 || i == 33);
      if (rec_bits[i] !== exp_b) bad++;
      if (i > 0 && rec_j[i] - rec_j[i-1] != 4) bad++;
    end
    chk("t1_bits_gaps_bad", bad, 0);

    // Frame 2: interval 0 acts as 1, empty payload.
    run_frame(0, 0, 0, 0, 0, -1);
    chk("t2_pulses", rec_bits.size(), 40);
    chk("t2_first_j", rec_j.size() > 0 ? rec_j[0] : -1, 1);
    chk("t2_done_j", done_j, 40);
    chk("t2_rd_cnt", rd_cnt, 0);
    chk("t2_phase_last_pre", rec_ph.size() > 31 ? rec_ph[31] : 2'd0, 1);
    chk("t2_phase_first_guard", rec_ph.size() > 32 ? rec_ph[32] : 2'd0, 3);

    // Frame 3: interval 2, second payload bit not valid.
    src_q = '{2'b11, 2'b00, 2'b10, 2'b11};
    run_frame(2, 4, 0, 0, 0, -1);
    chk("t3_pulses", rec_bits.size(), 44);
    chk("t3_done_j", done_j, 88);
    chk("t3_payload_bits", rec_bits.size() == 44 ?
        {rec_bits[32], rec_bits[33], rec_bits[34], rec_bits[35]} : 4'hf, 4'b1001);
    chk("t3_under_at_done", under_at_done, 1);

    // Frame 4: abort on 10th preamble strobe; new start clears underflow.
    src_q = '{2'b11, 2'b11};
    run_frame(3, 2, 30, 0, 0, -1);
    chk("t4_under_cleared", under_first, 0);
    chk("t4_pulses", rec_bits.size(), 9);
    chk("t4_no_done", done_j, -1);
    src_q.delete();
    src_q = '{2'b10, 2'b11};
    run_frame(1, 2, 0, 0, 0, -1);
    chk("t4b_pulses", rec_bits.size(), 42);
    chk("t4b_done_j", done_j, 42);
    chk("t4b_payload_bits", rec_bits.size() == 42 ? {rec_bits[32], rec_bits[33]} : 2'b11, 2'b01);

    // Frame 5: start mid-frame and in the done cycle are ignored.
    src_q.delete();
    src_q = '{2'b11, 2'b11};
    run_frame(1, 2, 0, 10, 1, -1);
    chk("t5_pulses", rec_bits.size(), 42);
    chk("t5_done_j", done_j, 42);
    chk("t5_rd_cnt", rd_cnt, 2);

    // Frame 6: reset during payload.
    src_q.delete();
    src_q = '{2'b11, 2'b11, 2'b11, 2'b11};
    run_frame(2, 4, 0, 0, 0, 67);
    chk("t6_pulses_before_rst", rec_bits.size(), 33);
    src_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    chk("t6_idle_busy", busy, 0);
    chk("t6_idle_phase", phase, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog actual=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
